ide_pio_ctrl: RTL and testbench
===============================

# ide_pio_ctrl

Parametrised IDE/boot-ROM bus controller for the A500 expansion, replacing the fixed single-cycle strobe decoder. It decodes the autoconfigured 64 KB IDE window on the 68000 bus and arbitrates it between the boot ROM and up to two IDE channels. It generates ATA PIO setup, strobe and hold timing from counters, honours IORDY with a timeout, and returns DTACK_n to the CPU.

## Interface
Parameters:
- NUM_CH, 1: IDE channels (1 or 2); channel select is A14 when 2.
- SETUP_CYC, 1: CLKCPU cycles from CS valid to IOR_n/IOW_n fall (1..15).
- STROBE_CYC, 2: minimum strobe-low cycles before DTACK (1..15).
- HOLD_CYC, 1: cycles CS held after strobe rise (1..15).
- ROM_WAIT, 1: cycles from ROM_OE_n fall to DTACK_n fall (0..15).
- IORDY_EN, 1: 1 = stretch strobe while IDE_IORDY low.
- TIMEOUT_CYC, 255: max IORDY wait cycles (1..1023).

Ports:
- CLKCPU  in  1  CPU clock, all state on rising edge.
- RESET_n  in  1  asynchronous, active-low reset.
- A_HIGH  in  8  CPU A[23:16].
- A12, A13, A14  in  1 each  register-block select; A14 is the channel select.
- RW_n  in  1  1 = read.
- AS_CPU_n  in  1  CPU address strobe.
- BASE_IDE  in  8  autoconfig base, compared with A_HIGH.
- IDE_CONFIGURED_n  in  1  0 = window enabled.
- IDE_IORDY  in  1  drive ready, synchronised internally (2 FFs).
- ROM_OE_n  out  1  boot-ROM output enable.
- IDE_IOR_n, IDE_IOW_n  out  1 each  ATA strobes.
- IDE_CS_n  out  2*NUM_CH  {CS1_n,CS0_n} per channel; channel c occupies bits [2c+1:2c].
- IDE_ACCESS  out  1  1 while an IDE cycle (SETUP..HOLD) is in progress; drives buffer direction.
- DTACK_n  out  1  CPU acknowledge.
- TIMEOUT  out  1  sticky: an IORDY wait expired.

## Operation
- Hit = !IDE_CONFIGURED_n && A_HIGH==BASE_IDE && !AS_CPU_n, sampled in IDLE only.
- Mode flag ide_mode: 0 after reset (reads go to ROM). The first write hit sets it to 1 permanently until reset, and that write is itself performed as an IDE write.
- FSM states: IDLE, ROM, SETUP, STROBE, WAIT_RDY, ACK, HOLD.
- IDLE + hit + RW_n + !ide_mode -> ROM: ROM_OE_n low. After ROM_WAIT cycles, DTACK_n goes low. When AS_CPU_n goes high, ROM_OE_n and DTACK_n go high and the FSM returns to IDLE.
- IDLE + hit otherwise -> SETUP. Latch rw and channel (A14, forced 0 when NUM_CH=1). Drive that channel's CS0_n=~A12 and CS1_n=~A13 and keep the other channel's CS_n = 2'b11.
- SETUP lasts SETUP_CYC cycles, then -> STROBE with IOR_n (read) or IOW_n (write) low.
- STROBE lasts STROBE_CYC cycles. At its end: if IORDY_EN && !iordy_sync, go to WAIT_RDY; otherwise go to ACK.
- WAIT_RDY holds the strobe low and counts. On iordy_sync=1 it goes to ACK. When the count reaches TIMEOUT_CYC it sets TIMEOUT and goes to ACK.
- ACK keeps the strobe low and drives DTACK_n low. It waits for AS_CPU_n high, then -> HOLD.
- HOLD drives the strobe high and DTACK_n high and holds CS for HOLD_CYC cycles. Then CS goes to all-1 and the FSM returns to IDLE.
- Abort: AS_CPU_n high in SETUP, STROBE or WAIT_RDY -> HOLD next edge. No DTACK is issued and TIMEOUT is unchanged.
- A new hit is not accepted until IDLE, so back-to-back CPU cycles are separated by HOLD.
- Counters: single shared down-counter, 10 bits, saturates at 0. It is loaded on each state entry.

## Timing
- Reset (async): all strobes, ROM_OE_n, DTACK_n and CS_n = 1; IDE_ACCESS=0; TIMEOUT=0; ide_mode=0; FSM=IDLE. Reset mid-cycle releases all outputs immediately.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Edge E0 samples the hit. CS becomes valid after E0.
- The strobe falls after edge E0+SETUP_CYC.
- DTACK_n falls after edge E0+SETUP_CYC+STROBE_CYC+W, where W = the number of WAIT_RDY cycles.
- The strobe and DTACK_n rise one edge after AS_CPU_n is sampled high. CS releases HOLD_CYC edges later.
- IORDY sync adds 2 cycles of latency. The bench must account for this.
- ROM read: ROM_OE_n falls after E0, and DTACK_n falls after E0+ROM_WAIT. With ROM_WAIT=0, both fall on the same edge.

## Test plan
- ROM read after reset with BASE_IDE=0xE9, A_HIGH=0xE9, RW_n=1, ROM_WAIT=1 -> ROM_OE_n low at E0+1, DTACK_n low at E0+2, no IDE strobe, IDE_ACCESS=0.
- First write, A12=1, A13=0, A14=0 -> IDE_CS_n[1:0]=2'b10, IOW_n low 1 cycle later, DTACK_n low 2 cycles after that. The next read goes to IDE, not ROM.
- NUM_CH=2, read with A14=1 -> only IDE_CS_n[3:2] active, [1:0]=2'b11 throughout.
- IORDY held low for 10 cycles after STROBE -> DTACK delayed by exactly 10 (+2 sync) cycles, TIMEOUT stays 0. Holding IORDY low permanently with TIMEOUT_CYC=20 -> DTACK after the timeout and TIMEOUT=1 until reset.
- AS_CPU_n released during SETUP -> no strobe pulse, DTACK_n stays high, CS released after HOLD_CYC cycles, FSM back in IDLE.
- RESET_n asserted during ACK -> all outputs return to inactive asynchronously, and the next read goes to ROM.

Source files
------------

// File: rtl/ide_pio_ctrl.sv
// IDE / boot-ROM bus controller for the 64 KB autoconfig window on the 68000 bus.
// Decodes the window and steers reads to the boot ROM until the first write,
// then to up to two ATA channels. ATA PIO setup, strobe and hold timing come
// from a shared 10-bit down-counter. IORDY can stretch the strobe, bounded by
// a timeout.
// Ports:
//   CLKCPU, RESET_n       clock, async active-low reset
//   A_HIGH, A12..A14      CPU address (A14 = channel select when NUM_CH == 2)
//   RW_n, AS_CPU_n        CPU read/write and address strobe
//   BASE_IDE              autoconfig base compared with A_HIGH
//   IDE_CONFIGURED_n      0 = window enabled
//   IDE_IORDY             drive ready (asynchronous)
//   ROM_OE_n              boot-ROM output enable
//   IDE_IOR_n, IDE_IOW_n  ATA strobes
//   IDE_CS_n              {CS1_n,CS0_n} per channel
//   IDE_ACCESS            high for the whole IDE cycle (buffer direction)
//   DTACK_n               CPU acknowledge
//   TIMEOUT               sticky IORDY timeout flag
module ide_pio_ctrl #(
    parameter int unsigned NUM_CH      = 1,
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 2,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned ROM_WAIT    = 1,
    parameter int unsigned IORDY_EN    = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  CLKCPU,
    input  logic                  RESET_n,
    input  logic [7:0]            A_HIGH,
    input  logic                  A12,
    input  logic                  A13,
    input  logic                  A14,
    input  logic                  RW_n,
    input  logic                  AS_CPU_n,
    input  logic [7:0]            BASE_IDE,
    input  logic                  IDE_CONFIGURED_n,
    input  logic                  IDE_IORDY,
    output logic                  ROM_OE_n,
    output logic                  IDE_IOR_n,
    output logic                  IDE_IOW_n,
    output logic [2*NUM_CH-1:0]   IDE_CS_n,
    output logic                  IDE_ACCESS,
    output logic                  DTACK_n,
    output logic                  TIMEOUT
);

    localparam int unsigned CS_W = 2 * NUM_CH;
    localparam int unsigned CNT_W = 10;

    // Counter reload values: a state lasting N cycles loads N-1 and leaves at 0.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LD     = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] ROM_LD    = (ROM_WAIT == 0) ? '0 : CNT_W'(ROM_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE, ROM, SETUP, STROBE, WAIT_RDY, ACK, HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic              mode_q, mode_d;
    logic              rom_oe_q, rom_oe_d;
    logic              ior_q, ior_d;
    logic              iow_q, iow_d;
    logic [CS_W-1:0]   cs_q, cs_d;
    logic              access_q, access_d;
    logic              dtack_q, dtack_d;
    logic              timeout_q, timeout_d;
    logic [1:0]        rdy_sync_q;
    logic              iordy_sync;
    logic              hit;
    logic              ch;
    logic              to_hold;

    assign iordy_sync = rdy_sync_q[1];
    assign hit = !IDE_CONFIGURED_n && (A_HIGH == BASE_IDE) && !AS_CPU_n;
    assign ch  = (NUM_CH == 2) ? A14 : 1'b0;

    // Two-flop synchroniser for the drive's IORDY
    always_ff @(posedge CLKCPU or negedge RESET_n) begin
        if (!RESET_n) rdy_sync_q <= 2'b00;
        else          rdy_sync_q <= {rdy_sync_q[0], IDE_IORDY};
    end

    // State, counter and registered outputs
    always_ff @(posedge CLKCPU or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rw_q      <= 1'b1;
            mode_q    <= 1'b0;
            rom_oe_q  <= 1'b1;
            ior_q     <= 1'b1;
            iow_q     <= 1'b1;
            cs_q      <= '1;
            access_q  <= 1'b0;
            dtack_q   <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            mode_q    <= mode_d;
            rom_oe_q  <= rom_oe_d;
            ior_q     <= ior_d;
            iow_q     <= iow_d;
            cs_q      <= cs_d;
            access_q  <= access_d;
            dtack_q   <= dtack_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        rw_d      = rw_q;
        mode_d    = mode_q;
        rom_oe_d  = rom_oe_q;
        ior_d     = ior_q;
        iow_d     = iow_q;
        cs_d      = cs_q;
        access_d  = access_q;
        dtack_d   = dtack_q;
        timeout_d = timeout_q;
        to_hold   = 1'b0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (RW_n && !mode_q) begin
                        state_d  = ROM;
                        cnt_d    = ROM_LD;
                        rom_oe_d = 1'b0;
                        dtack_d  = (ROM_WAIT == 0) ? 1'b0 : 1'b1;
                    end else begin
                        state_d  = SETUP;
                        cnt_d    = SETUP_LD;
                        rw_d     = RW_n;
                        access_d = 1'b1;
                        // The first write switches the window to IDE for good
                        if (!RW_n) mode_d = 1'b1;
                        for (int unsigned c = 0; c < NUM_CH; c++) begin
                            cs_d[2*c +: 2] = (ch == 1'(c)) ? {~A13, ~A12} : 2'b11;
                        end
                    end
                end
            end
            ROM: begin
                if (AS_CPU_n) begin
                    state_d  = IDLE;
                    rom_oe_d = 1'b1;
                    dtack_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    dtack_d = 1'b0;
                end
            end
            SETUP: begin
                if (AS_CPU_n) begin
                    to_hold = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                    ior_d   = !rw_q;
                    iow_d   = rw_q;
                end
            end
            STROBE: begin
                if (AS_CPU_n) begin
                    to_hold = 1'b1;
                end else if (cnt_q == '0) begin
                    if ((IORDY_EN != 0) && !iordy_sync) begin
                        state_d = WAIT_RDY;
                        cnt_d   = TO_LD;
                    end else begin
                        state_d = ACK;
                        dtack_d = 1'b0;
                    end
                end
            end
            WAIT_RDY: begin
                if (AS_CPU_n) begin
                    to_hold = 1'b1;
                end else if (iordy_sync) begin
                    state_d = ACK;
                    dtack_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d   = ACK;
                    dtack_d   = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            ACK: begin
                if (AS_CPU_n) to_hold = 1'b1;
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d  = IDLE;
                    cs_d     = '1;
                    access_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobe and DTACK release together; CS stays for the hold time
        if (to_hold) begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
            ior_d   = 1'b1;
            iow_d   = 1'b1;
            dtack_d = 1'b1;
        end
    end

    assign ROM_OE_n   = rom_oe_q;
    assign IDE_IOR_n  = ior_q;
    assign IDE_IOW_n  = iow_q;
    assign IDE_CS_n   = cs_q;
    assign IDE_ACCESS = access_q;
    assign DTACK_n    = dtack_q;
    assign TIMEOUT    = timeout_q;

endmodule

// File: tb/tb_ide_pio_ctrl.sv
// Directed bench for ide_pio_ctrl: a cycle-by-cycle vector table for the
// two-channel instance plus hand-written sequences for ROM_WAIT=0 and
// reset in the middle of an acknowledged cycle.
module tb_ide_pio_ctrl;

    logic       CLKCPU;
    logic       RESET_n;
    logic [7:0] A_HIGH;
    logic       A12, A13, A14;
    logic       RW_n;
    logic       AS_CPU_n;
    logic [7:0] BASE_IDE;
    logic       IDE_CONFIGURED_n;
    logic       IDE_IORDY;

    logic       rom0, ior0, iow0, acc0, dt0, to0;
    logic [3:0] cs0;
    logic       rom1, ior1, iow1, acc1, dt1, to1;
    logic [1:0] cs1;

    int n_vec = 0;
    int n_err = 0;

    // Two channels, 20-cycle IORDY timeout
    ide_pio_ctrl #(
        .NUM_CH(2), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1),
        .ROM_WAIT(1), .IORDY_EN(1), .TIMEOUT_CYC(20)
    ) u0 (
        .CLKCPU(CLKCPU), .RESET_n(RESET_n), .A_HIGH(A_HIGH),
        .A12(A12), .A13(A13), .A14(A14), .RW_n(RW_n), .AS_CPU_n(AS_CPU_n),
        .BASE_IDE(BASE_IDE), .IDE_CONFIGURED_n(IDE_CONFIGURED_n),
        .IDE_IORDY(IDE_IORDY), .ROM_OE_n(rom0), .IDE_IOR_n(ior0),
        .IDE_IOW_n(iow0), .IDE_CS_n(cs0), .IDE_ACCESS(acc0),
        .DTACK_n(dt0), .TIMEOUT(to0)
    );

    // One channel, zero ROM wait, IORDY ignored
    ide_pio_ctrl #(
        .NUM_CH(1), .SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(2),
        .ROM_WAIT(0), .IORDY_EN(0), .TIMEOUT_CYC(20)
    ) u1 (
        .CLKCPU(CLKCPU), .RESET_n(RESET_n), .A_HIGH(A_HIGH),
        .A12(A12), .A13(A13), .A14(A14), .RW_n(RW_n), .AS_CPU_n(AS_CPU_n),
        .BASE_IDE(BASE_IDE), .IDE_CONFIGURED_n(IDE_CONFIGURED_n),
        .IDE_IORDY(IDE_IORDY), .ROM_OE_n(rom1), .IDE_IOR_n(ior1),
        .IDE_IOW_n(iow1), .IDE_CS_n(cs1), .IDE_ACCESS(acc1),
        .DTACK_n(dt1), .TIMEOUT(to1)
    );

    initial CLKCPU = 1'b0;
    always #5 CLKCPU = ~CLKCPU;

    typedef struct {
        logic       as_n;
        logic       rw_n;
        logic       cfg_n;
        logic [7:0] ah;
        logic [2:0] a;      // {A14, A13, A12}
        logic       rdy;
        logic [9:0] exp;    // {rom, ior, iow, cs[3:0], access, dtack, timeout}
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] ex(input logic rom, input logic ior, input logic iow,
                                      input logic [3:0] cs, input logic acc,
                                      input logic dt, input logic to);
        return {rom, ior, iow, cs, acc, dt, to};
    endfunction

    function automatic logic [9:0] act0();
        return {rom0, ior0, iow0, cs0, acc0, dt0, to0};
    endfunction

    function automatic logic [9:0] act1();
        return {rom1, ior1, iow1, 2'b11, cs1, acc1, dt1, to1};
    endfunction

    task automatic add(input logic as_n, input logic rw_n, input logic cfg_n,
                       input logic [7:0] ah, input logic [2:0] a, input logic rdy,
                       input logic [9:0] e);
        vec_t v;
        v.as_n = as_n; v.rw_n = rw_n; v.cfg_n = cfg_n; v.ah = ah;
        v.a = a; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [9:0] got, input logic [9:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b required %b (rom,ior,iow,cs[3:0],acc,dtack,to)",
                     name, got, want);
        end
    endtask

    // Drive inputs on the falling edge, then wait past the next rising edge
    task automatic step(input logic as_n, input logic rw_n, input logic cfg_n,
                        input logic [7:0] ah, input logic [2:0] a, input logic rdy);
        @(negedge CLKCPU);
        AS_CPU_n = as_n; RW_n = rw_n; IDE_CONFIGURED_n = cfg_n; A_HIGH = ah;
        {A14, A13, A12} = a; IDE_IORDY = rdy;
        @(posedge CLKCPU);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    localparam logic [7:0] B = 8'hE9;

    initial begin
        logic [9:0] idle_e, idle_t;
        idle_e = ex(1, 1, 1, 4'hF, 0, 1, 0);
        idle_t = ex(1, 1, 1, 4'hF, 0, 1, 1);

        // Vector table
        // No hit: window disabled, then wrong base
        add(0, 1, 1, B,     3'b000, 1, idle_e);
        add(0, 1, 0, 8'hE8, 3'b000, 1, idle_e);
        add(1, 1, 0, B,     3'b000, 1, idle_e);
        // ROM read, ROM_WAIT=1
        add(0, 1, 0, B, 3'b000, 1, ex(0, 1, 1, 4'hF, 0, 1, 0));
        add(0, 1, 0, B, 3'b000, 1, ex(0, 1, 1, 4'hF, 0, 0, 0));
        add(0, 1, 0, B, 3'b000, 1, ex(0, 1, 1, 4'hF, 0, 0, 0));
        add(1, 1, 0, B, 3'b000, 1, idle_e);
        add(1, 1, 0, B, 3'b000, 1, idle_e);
        // First write, A12=1: CS0_n low, becomes an IDE write
        add(0, 0, 0, B, 3'b001, 1, ex(1, 1, 1, 4'b1110, 1, 1, 0));
        add(0, 0, 0, B, 3'b001, 1, ex(1, 1, 0, 4'b1110, 1, 1, 0));
        add(0, 0, 0, B, 3'b001, 1, ex(1, 1, 0, 4'b1110, 1, 1, 0));
        add(0, 0, 0, B, 3'b001, 1, ex(1, 1, 0, 4'b1110, 1, 0, 0));
        add(0, 0, 0, B, 3'b001, 1, ex(1, 1, 0, 4'b1110, 1, 0, 0));
        add(1, 0, 0, B, 3'b001, 1, ex(1, 1, 1, 4'b1110, 1, 1, 0));
        for (int i = 0; i < 3; i++) add(1, 1, 0, B, 3'b001, 1, idle_e);
        // Read on channel 1 (A14=1, A13=1): goes to IDE now
        add(0, 1, 0, B, 3'b110, 1, ex(1, 1, 1, 4'b0111, 1, 1, 0));
        add(0, 1, 0, B, 3'b110, 1, ex(1, 0, 1, 4'b0111, 1, 1, 0));
        add(0, 1, 0, B, 3'b110, 1, ex(1, 0, 1, 4'b0111, 1, 1, 0));
        add(0, 1, 0, B, 3'b110, 1, ex(1, 0, 1, 4'b0111, 1, 0, 0));
        add(1, 1, 0, B, 3'b110, 1, ex(1, 1, 1, 4'b0111, 1, 1, 0));
        for (int i = 0; i < 3; i++) add(1, 1, 0, B, 3'b110, 1, idle_e);
        // IORDY low through 10 cycles after the strobe window: 12 wait cycles
        add(0, 1, 0, B, 3'b011, 0, ex(1, 1, 1, 4'b1100, 1, 1, 0));
        for (int k = 1; k <= 14; k++)
            add(0, 1, 0, B, 3'b011, (k <= 12) ? 1'b0 : 1'b1, ex(1, 0, 1, 4'b1100, 1, 1, 0));
        add(0, 1, 0, B, 3'b011, 1, ex(1, 0, 1, 4'b1100, 1, 0, 0));
        add(1, 1, 0, B, 3'b011, 1, ex(1, 1, 1, 4'b1100, 1, 1, 0));
        for (int i = 0; i < 3; i++) add(1, 1, 0, B, 3'b011, 1, idle_e);
        // IORDY stuck low: DTACK after 20 wait cycles with TIMEOUT set
        add(0, 1, 0, B, 3'b011, 0, ex(1, 1, 1, 4'b1100, 1, 1, 0));
        for (int k = 1; k <= 22; k++)
            add(0, 1, 0, B, 3'b011, 0, ex(1, 0, 1, 4'b1100, 1, 1, 0));
        add(0, 1, 0, B, 3'b011, 0, ex(1, 0, 1, 4'b1100, 1, 0, 1));
        add(0, 1, 0, B, 3'b011, 0, ex(1, 0, 1, 4'b1100, 1, 0, 1));
        add(1, 1, 0, B, 3'b011, 1, ex(1, 1, 1, 4'b1100, 1, 1, 1));
        for (int i = 0; i < 3; i++) add(1, 1, 0, B, 3'b011, 1, idle_t);
        // Abort in SETUP: no strobe, no DTACK, CS held one hold cycle
        add(0, 1, 0, B, 3'b001, 1, ex(1, 1, 1, 4'b1110, 1, 1, 1));
        add(1, 1, 0, B, 3'b001, 1, ex(1, 1, 1, 4'b1110, 1, 1, 1));
        for (int i = 0; i < 3; i++) add(1, 1, 0, B, 3'b001, 1, idle_t);
        // Abort in STROBE
        add(0, 1, 0, B, 3'b001, 1, ex(1, 1, 1, 4'b1110, 1, 1, 1));
        add(0, 1, 0, B, 3'b001, 1, ex(1, 0, 1, 4'b1110, 1, 1, 1));
        add(1, 1, 0, B, 3'b001, 1, ex(1, 1, 1, 4'b1110, 1, 1, 1));
        for (int i = 0; i < 3; i++) add(1, 1, 0, B, 3'b001, 1, idle_t);

        // Reset state
        RESET_n = 1'b0; AS_CPU_n = 1'b1; RW_n = 1'b1; A_HIGH = 8'h00;
        {A14, A13, A12} = 3'b000; BASE_IDE = B; IDE_CONFIGURED_n = 1'b0;
        IDE_IORDY = 1'b1;
        #12;
        cmp("reset_u0", act0(), idle_e);
        cmp("reset_u1", act1(), idle_e);
        @(negedge CLKCPU);
        RESET_n = 1'b1;
        step(1, 1, 0, B, 3'b000, 1);
        step(1, 1, 0, B, 3'b000, 1);

        // ROM_WAIT=0: ROM_OE_n and DTACK_n fall on the same edge
        step(0, 1, 0, B, 3'b000, 1);
        cmp("rom_e0_u0", act0(), ex(0, 1, 1, 4'hF, 0, 1, 0));
        cmp("rom_e0_u1", act1(), ex(0, 1, 1, 4'hF, 0, 0, 0));
        step(0, 1, 0, B, 3'b000, 1);
        cmp("rom_e1_u0", act0(), ex(0, 1, 1, 4'hF, 0, 0, 0));
        step(1, 1, 0, B, 3'b000, 1);
        cmp("rom_end_u1", act1(), idle_e);
        step(1, 1, 0, B, 3'b000, 1);

        foreach (vecs[i]) begin
            step(vecs[i].as_n, vecs[i].rw_n, vecs[i].cfg_n, vecs[i].ah, vecs[i].a, vecs[i].rdy);
            cmp($sformatf("vec%0d", i), act0(), vecs[i].exp);
        end

        // Reset while in ACK, then the next read must go to ROM again
        step(0, 1, 0, B, 3'b001, 1);
        step(0, 1, 0, B, 3'b001, 1);
        step(0, 1, 0, B, 3'b001, 1);
        step(0, 1, 0, B, 3'b001, 1);
        cmp("ack_before_reset", act0(), ex(1, 0, 1, 4'b1110, 1, 0, 1));
        #2;
        RESET_n = 1'b0;
        #1;
        cmp("async_reset_u0", act0(), idle_e);
        cmp("async_reset_u1", act1(), idle_e);
        @(negedge CLKCPU);
        RESET_n = 1'b1; AS_CPU_n = 1'b1;
        step(1, 1, 0, B, 3'b000, 1);
        step(0, 1, 0, B, 3'b000, 1);
        cmp("rom_after_reset_u0", act0(), ex(0, 1, 1, 4'hF, 0, 1, 0));
        cmp("rom_after_reset_u1", act1(), ex(0, 1, 1, 4'hF, 0, 0, 0));
        step(0, 1, 0, B, 3'b000, 1);
        cmp("rom_after_reset_dtack", act0(), ex(0, 1, 1, 4'hF, 0, 0, 0));
        step(1, 1, 0, B, 3'b000, 1);
        cmp("rom_after_reset_end", act0(), idle_e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
